// File: rtl/booth_mul_sat_if.sv
// Operand/result bundle for booth_mul_sat: level arm/fin handshake plus data.
// sat_flag exists only when BOOTH_MUL_SAT_FLAG_EN is defined.
interface booth_mul_sat_if #(
    parameter int A1_LEN  = 64,
    parameter int A2_LEN  = 64,
    parameter int OUT_LEN = 64
);
    logic                       arm;
    logic [A1_LEN-1:0]          a1;
    logic [A2_LEN-1:0]          a2;
    logic [A1_LEN+A2_LEN-1:0]   outn;
    logic [OUT_LEN-1:0]         outsat;
    logic                       fin;
`ifdef BOOTH_MUL_SAT_FLAG_EN
    logic                       sat_flag;
`endif

    modport master (
        output arm, a1, a2,
        input  outn, outsat, fin
`ifdef BOOTH_MUL_SAT_FLAG_EN
        , input sat_flag
`endif
    );

    modport slave (
        input  arm, a1, a2,
        output outn, outsat, fin
`ifdef BOOTH_MUL_SAT_FLAG_EN
        , output sat_flag
`endif
    );
endinterface

// File: rtl/booth_mul_sat.sv
// Sequential radix-2 Booth signed multiplier with floor-truncate and saturate.
// Optional sat_flag output is enabled by defining BOOTH_MUL_SAT_FLAG_EN.
module booth_mul_sat #(
    parameter int A1_LEN    = 64,
    parameter int A2_LEN    = 64,
    parameter int A2LEN_SIZ = 7,
    parameter int FRAC      = 43,
    parameter int OUT_LEN   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_mul_sat_if.slave     bus
);
    localparam int PROD_W = A1_LEN + A2_LEN;
    localparam int ACC_W  = A1_LEN + 1;
    localparam int PW     = PROD_W + 2;
    localparam int W      = PROD_W - FRAC;
    localparam int L      = W - OUT_LEN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [A2LEN_SIZ-1:0]   cnt_reg;
    logic [PW-1:0]          prod_reg, prod_next;
    logic [A1_LEN-1:0]      mcand_reg;
    logic [PROD_W-1:0]      outn_reg;
    logic [ACC_W-1:0]       acc, acc_sum, mcand_ext;
    logic                   last_step;
    logic                   fin;

    assign last_step = (cnt_reg == A2LEN_SIZ'(A2_LEN - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; dropping arm in RUN aborts without touching outn
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.arm) state_next = RUN;
            RUN:     if (!bus.arm) state_next = IDLE;
                     else if (last_step) state_next = DONE;
            DONE:    if (!bus.arm) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        fin = 1'b0;
        if (state_reg == DONE) fin = 1'b1;
    end

    // One Booth step; the extra accumulator bit keeps a1 = min exact
    always_comb begin
        acc       = prod_reg[PW-1 -: ACC_W];
        mcand_ext = {mcand_reg[A1_LEN-1], mcand_reg};
        case (prod_reg[1:0])
            2'b01:   acc_sum = acc + mcand_ext;
            2'b10:   acc_sum = acc - mcand_ext;
            default: acc_sum = acc;
        endcase
        prod_next = {acc_sum[ACC_W-1], acc_sum, prod_reg[A2_LEN:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            prod_reg  <= '0;
            mcand_reg <= '0;
            outn_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: if (bus.arm) begin
                    mcand_reg <= bus.a1;
                    prod_reg  <= {{ACC_W{1'b0}}, bus.a2, 1'b0};
                    cnt_reg   <= '0;
                end
                RUN: if (bus.arm) begin
                    prod_reg <= prod_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (last_step) outn_reg <= prod_next[PROD_W:1];
                end
                default: ;
            endcase
        end
    end

    assign bus.outn = outn_reg;
    assign bus.fin  = fin;

    // Floor truncation is just dropping the FRAC LSBs of the two's-complement product
    logic [W-1:0] trunc;
    logic         clamp;
    assign trunc = outn_reg[PROD_W-1:FRAC];

    generate
        if (L == 0) begin : g_nosat
            assign clamp      = 1'b0;
            assign bus.outsat = trunc;
        end else begin : g_sat
            logic [L:0] top;
            assign top        = trunc[W-1:OUT_LEN-1];
            assign clamp      = !((&top) || !(|top));
            assign bus.outsat = !clamp    ? trunc[OUT_LEN-1:0] :
                                trunc[W-1] ? {1'b1, {(OUT_LEN-1){1'b0}}} :
                                             {1'b0, {(OUT_LEN-1){1'b1}}};
        end
    endgenerate

`ifdef BOOTH_MUL_SAT_FLAG_EN
    assign bus.sat_flag = clamp;
`endif
endmodule

// File: tb/tb_booth_mul_sat.sv
// Directed scoreboard bench for booth_mul_sat: products, saturation, handshake, abort.
module tb_booth_mul_sat;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    booth_mul_sat_if #(.A1_LEN(64), .A2_LEN(64), .OUT_LEN(64)) bus ();

    booth_mul_sat #(
        .A1_LEN(64), .A2_LEN(64), .A2LEN_SIZ(7), .FRAC(43), .OUT_LEN(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [127:0] outn;
        logic [63:0]  outsat;
        logic         flag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic exp_t model(input logic signed [63:0] x, input logic signed [63:0] y);
        exp_t e;
        logic signed [127:0] px, py, p, t, maxp, minn;
        px = x; py = y;
        p  = px * py;
        t  = p >>> 43;
        maxp = 128'sh7FFF_FFFF_FFFF_FFFF;
        minn = ~maxp;
        e.outn = p;
        if (t > maxp) begin
            e.outsat = 64'h7FFF_FFFF_FFFF_FFFF; e.flag = 1'b1;
        end else if (t < minn) begin
            e.outsat = 64'h8000_0000_0000_0000; e.flag = 1'b1;
        end else begin
            e.outsat = t[63:0]; e.flag = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] x, input logic [63:0] y, input bit push);
        bus.a1  = x;
        bus.a2  = y;
        bus.arm = 1'b1;
        if (push) sb.push_back(model(x, y));
    endtask

    // Waits for fin, checks latency, pops scoreboard; optionally scrambles a1 mid-run
    task automatic finish_op(input string tag, input bit scramble, output exp_t e);
        int n = 0;
        do begin
            tick();
            n++;
            if (scramble && n == 10) bus.a1 = {$urandom, $urandom};
        end while (bus.fin !== 1'b1 && n < 200);
        $display("op %s: fin after %0d edges outn=%h outsat=%h", tag, n, bus.outn, bus.outsat);
        chk({tag, "_latency"}, 128'(n), 128'(65));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 128'(0), 128'(1));
            e.outn = '0; e.outsat = '0; e.flag = 1'b0;
        end else begin
            e = sb.pop_front();
            chk({tag, "_outn"}, bus.outn, e.outn);
            chk({tag, "_outsat"}, 128'(bus.outsat), 128'(e.outsat));
`ifdef BOOTH_MUL_SAT_FLAG_EN
            chk({tag, "_flag"}, 128'(bus.sat_flag), 128'(e.flag));
`endif
        end
    endtask

    task automatic drop_arm(input string tag);
        bus.arm = 1'b0;
        tick();
        chk({tag, "_fin_drop"}, 128'(bus.fin), 128'(0));
    endtask

    task automatic watch_no_fin(input string tag, input logic [127:0] exp_outn);
        int hits = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.fin === 1'b1) hits++;
        end
        chk({tag, "_no_fin"}, 128'(hits), 128'(0));
        chk({tag, "_outn_kept"}, bus.outn, exp_outn);
    endtask

    initial begin : main
        exp_t e;
        rst_n   = 1'b0;
        bus.arm = 1'b0;
        bus.a1  = '0;
        bus.a2  = '0;
        repeat (3) tick();
        chk("reset_fin", 128'(bus.fin), 128'(0));
        chk("reset_outn", bus.outn, 128'(0));
        chk("reset_outsat", 128'(bus.outsat), 128'(0));
`ifdef BOOTH_MUL_SAT_FLAG_EN
        chk("reset_flag", 128'(bus.sat_flag), 128'(0));
`endif
        rst_n = 1'b1;
        tick();

        drive(64'd3, -64'sd5, 1'b1);
        finish_op("int_3x-5", 1'b0, e);
        drop_arm("int_3x-5");

        drive(64'd3 << 42, 64'd1 << 44, 1'b1);
        finish_op("fix_1.5x2", 1'b0, e);
        drop_arm("fix_1.5x2");

        drive(64'd1 << 62, 64'd1 << 62, 1'b1);
        finish_op("sat_pos", 1'b0, e);
        drop_arm("sat_pos");

        drive(-(64'sd1 <<< 62), 64'd1 << 62, 1'b1);
        finish_op("sat_neg", 1'b0, e);
        drop_arm("sat_neg");

        drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        finish_op("min_x_min", 1'b0, e);
        drop_arm("min_x_min");

        // Operand change mid-run must not matter; hold arm past fin
        drive(64'h0000_1234_5678_9ABC, -64'sd987654321, 1'b1);
        finish_op("scramble", 1'b1, e);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_fin", 128'(bus.fin), 128'(1));
            chk("hold_outn", bus.outn, e.outn);
        end
        drop_arm("hold");
        chk("idle_outn_kept", bus.outn, e.outn);

        // Re-arm on the first possible edge after the drop
        drive(-64'sd77, 64'd1 << 50, 1'b1);
        finish_op("rearm", 1'b0, e);
        drop_arm("rearm");

        // Abort by arm drop after ~30 steps: no fin, outn unchanged
        drive(64'd11, 64'd13, 1'b0);
        repeat (31) tick();
        bus.arm = 1'b0;
        watch_no_fin("arm_abort", e.outn);

        // Abort by reset after ~30 steps
        drive(64'd11, 64'd13, 1'b0);
        repeat (31) tick();
        bus.arm = 1'b0;
        rst_n   = 1'b0;
        tick();
        chk("rst_abort_fin", 128'(bus.fin), 128'(0));
        chk("rst_abort_outn", bus.outn, 128'(0));
        rst_n = 1'b1;
        watch_no_fin("rst_abort", 128'(0));

        // Normal operation resumes from IDLE
        tick();
        drive(-64'sd123456789, -64'sd987, 1'b1);
        finish_op("post_reset", 1'b0, e);
        drop_arm("post_reset");

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
